// File: rtl/gon_pkg.sv
// Shared GON definitions: default tag/value widths and the psum collector FSM encoding.
package gon_pkg;

    localparam int GON_ROW_LEN   = 4;
    localparam int GON_ID_LEN    = 5;
    localparam int GON_VALUE_LEN = 32;
    localparam int GON_ADDR_LEN  = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/gon_psum_collector_if.sv
// GON request/response and GLB write channels seen by the psum collector.
interface gon_psum_collector_if
    import gon_pkg::*;
#(
    parameter int ROW_LEN   = GON_ROW_LEN,
    parameter int ID_LEN    = GON_ID_LEN,
    parameter int VALUE_LEN = GON_VALUE_LEN,
    parameter int ADDR_LEN  = GON_ADDR_LEN
);
    logic                 gon_ready;
    logic [ROW_LEN-1:0]   gon_row_tag;
    logic [ID_LEN-1:0]    gon_col_tag;
    logic                 gon_enable;
    logic [VALUE_LEN-1:0] gon_value;
    logic                 glb_valid;
    logic [ADDR_LEN-1:0]  glb_addr;
    logic [VALUE_LEN-1:0] glb_data;
    logic                 glb_ready;

    modport master (
        output gon_ready, gon_row_tag, gon_col_tag, glb_valid, glb_addr, glb_data,
        input  gon_enable, gon_value, glb_ready
    );

    modport slave (
        input  gon_ready, gon_row_tag, gon_col_tag, glb_valid, glb_addr, glb_data,
        output gon_enable, gon_value, glb_ready
    );
endinterface

// File: rtl/gon_sync_fifo.sv
// Small first-word fall-through FIFO; head is visible combinationally while not empty.
// A write is accepted when not full, or when full together with a read.
module gon_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_wr, do_rd;

    assign empty  = (count == '0);
    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign do_rd  = rd_en && !empty;
    assign do_wr  = wr_en && (!full || do_rd);
    // Gate the head so stale words never leak onto the bus while empty.
    assign rd_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

// File: rtl/gon_psum_collector.sv
// Walks a row-major tag grid, fetching one psum per tag from the GON, and streams
// (addr, data) to the GLB; new requests are withheld while the output FIFO is full.
module gon_psum_collector
    import gon_pkg::*;
#(
    parameter int ROW_LEN    = GON_ROW_LEN,
    parameter int ID_LEN     = GON_ID_LEN,
    parameter int VALUE_LEN  = GON_VALUE_LEN,
    parameter int ADDR_LEN   = GON_ADDR_LEN,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ROW_LEN-1:0]  num_rows,
    input  logic [ID_LEN-1:0]   num_cols,
    input  logic [ADDR_LEN-1:0] base_addr,
    output logic                busy,
    output logic                done,
    output logic                err,
    gon_psum_collector_if.master bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [2:0]                    state;
    logic [ROW_LEN-1:0]            rows_q, row;
    logic [ID_LEN-1:0]             cols_q, col;
    logic [ADDR_LEN-1:0]           addr_cnt;
    logic [TMO_W-1:0]              tmo_cnt;
    logic                          fifo_full, fifo_empty;
    logic                          push, pop, stray, last_col, last, tmo_hit;
    logic [ADDR_LEN+VALUE_LEN-1:0] head;

    assign push     = (state == S_WAIT) && bus.gon_enable;
    assign stray    = (state != S_WAIT) && bus.gon_enable;
    assign pop      = !fifo_empty && bus.glb_ready;
    assign last_col = (col == cols_q - ID_LEN'(1));
    assign last     = last_col && (row == rows_q - ROW_LEN'(1));
    assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    assign busy            = (state != S_IDLE);
    assign bus.gon_ready   = (state == S_ISSUE) && !fifo_full;
    assign bus.gon_row_tag = row;
    assign bus.gon_col_tag = col;
    assign bus.glb_valid   = !fifo_empty;
    assign {bus.glb_addr, bus.glb_data} = head;

    gon_sync_fifo #(
        .WIDTH (ADDR_LEN + VALUE_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push),
        .wr_dat ({addr_cnt, bus.gon_value}),
        .rd_en  (pop),
        .rd_dat (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rows_q   <= '0;
            cols_q   <= '0;
            row      <= '0;
            col      <= '0;
            addr_cnt <= '0;
            tmo_cnt  <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            case (state)
                S_IDLE: if (start) begin
                    rows_q   <= num_rows;
                    cols_q   <= num_cols;
                    row      <= '0;
                    col      <= '0;
                    addr_cnt <= base_addr;
                    err      <= 1'b0;
                    state    <= (num_rows == '0 || num_cols == '0) ? S_DONE : S_ISSUE;
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    if (!fifo_full) state <= S_WAIT;
                end
                S_WAIT: if (bus.gon_enable) begin
                    addr_cnt <= addr_cnt + ADDR_LEN'(1);
                    if (last_col) begin
                        col <= '0;
                        row <= row + ROW_LEN'(1);
                    end else begin
                        col <= col + ID_LEN'(1);
                    end
                    state <= last ? S_DRAIN : S_ISSUE;
                end else if (tmo_hit) begin
                    err   <= 1'b1;
                    state <= S_DRAIN;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
                S_DRAIN: if (fifo_empty) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            // A response nobody asked for wins over the clear-on-start.
            if (stray) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gon_psum_collector.sv
// Directed table-driven bench for gon_psum_collector with a 2-cycle GON responder model.
module tb_gon_psum_collector;
    localparam int DLY = 2;

    typedef struct {
        int rows; int cols; int base; int hold; int allowed;
        int n_req; int n_words; int done_cyc; int busy_n; int err_cyc; int req_at_hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  num_rows;
    logic [4:0]  num_cols;
    logic [15:0] base_addr;
    logic        busy, done, err;

    gon_psum_collector_if #(.ROW_LEN(4), .ID_LEN(5), .VALUE_LEN(32), .ADDR_LEN(16)) bus ();

    gon_psum_collector #(
        .ROW_LEN(4), .ID_LEN(5), .VALUE_LEN(32), .ADDR_LEN(16), .FIFO_DEPTH(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .num_cols(num_cols),
        .base_addr(base_addr), .busy(busy), .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int c = 0;
    int job = 0;
    int allowed = 99;
    bit in_job = 1'b0;

    int     req_q[$];
    longint wq[$];
    int     resp_at = -1, resp_r = 0, resp_c = 0;
    int     m_done_n, m_done_cyc, m_busy_n, m_err_cyc;
    bit     m_err1;

    function automatic logic [31:0] val(input int j, input int r, input int cc);
        return 32'(32'hC0DE0000 + j * 4096 + r * 256 + cc);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit stray);
        @(posedge clk);
        #1;
        c++;
        bus.gon_enable = stray || (c == resp_at);
        bus.gon_value  = (c == resp_at) ? val(job, resp_r, resp_c) : 32'h0;
    endtask

    // Monitor and GON responder bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (in_job && c == 0) begin
            req_q.delete();
            wq.delete();
            m_done_n = 0; m_done_cyc = -1; m_busy_n = 0; m_err_cyc = -1; m_err1 = 1'b0;
            resp_at = -1;
        end else if (in_job) begin
            if (bus.gon_ready) begin
                req_q.push_back(int'(bus.gon_row_tag) * 32 + int'(bus.gon_col_tag));
                if (req_q.size() <= allowed) begin
                    resp_at = c + DLY;
                    resp_r  = int'(bus.gon_row_tag);
                    resp_c  = int'(bus.gon_col_tag);
                end
            end
            if (bus.glb_valid && bus.glb_ready) wq.push_back(longint'({bus.glb_addr, bus.glb_data}));
            if (busy) m_busy_n++;
            if (done) begin
                m_done_n++;
                if (m_done_cyc < 0) m_done_cyc = c;
            end
            if (err && m_err_cyc < 0) m_err_cyc = c;
            if (c == 1) m_err1 = err;
        end
        if (rst) resp_at = -1;
    end

    task automatic run_vec(input vec_t v, input int id);
        logic [47:0] exp_w;
        int r, cc;
        @(posedge clk);
        #1;
        job++;
        allowed = v.allowed;
        c = 0;
        in_job = 1'b1;
        num_rows = 4'(v.rows);
        num_cols = 5'(v.cols);
        base_addr = 16'(v.base);
        bus.glb_ready = (v.hold == 0);
        bus.gon_enable = 1'b0;
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        while (c < 300 && !(m_done_n > 0 && c >= m_done_cyc + 3)) begin
            if (v.hold > 0 && c == v.hold) begin
                chk($sformatf("v%0d_req_at_hold", id), req_q.size(), v.req_at_hold);
                bus.glb_ready = 1'b1;
            end
            step(1'b0);
        end
        in_job = 1'b0;
        chk($sformatf("v%0d_req_count", id), req_q.size(), v.n_req);
        for (int k = 0; k < v.n_req && k < req_q.size(); k++)
            chk($sformatf("v%0d_tag%0d", id, k), req_q[k], (k / v.cols) * 32 + (k % v.cols));
        chk($sformatf("v%0d_word_count", id), wq.size(), v.n_words);
        for (int k = 0; k < v.n_words && k < wq.size(); k++) begin
            r  = k / v.cols;
            cc = k % v.cols;
            exp_w = {16'(v.base + k), val(job, r, cc)};
            chk($sformatf("v%0d_word%0d", id, k), wq[k], longint'(exp_w));
        end
        chk($sformatf("v%0d_done_pulses", id), m_done_n, 1);
        chk($sformatf("v%0d_done_cycle", id), m_done_cyc, v.done_cyc);
        chk($sformatf("v%0d_busy_cycles", id), m_busy_n, v.busy_n);
        chk($sformatf("v%0d_err_cycle", id), m_err_cyc, v.err_cyc);
        chk($sformatf("v%0d_err_after_start", id), m_err1, 0);
    endtask

    vec_t vt[5];
    vec_t clean;

    initial begin
        //           rows cols base     hold allow nreq nwrd done busy errc reqhold
        vt[0] = '{2, 3, 'h100,  0,  99,  6,   6,  22,  21,  -1,  0};
        vt[1] = '{2, 3, 'h100,  20, 99,  6,   6,  30,  29,  -1,  4};
        vt[2] = '{2, 0, 'h040,  0,  99,  0,   0,  2,   1,   -1,  0};
        vt[3] = '{2, 3, 'h200,  0,  2,   3,   2,  18,  17,  16,  0};
        vt[4] = '{1, 4, 'hFFFE, 0,  99,  4,   4,  16,  15,  -1,  0};
        clean = '{2, 2, 'h300,  0,  99,  4,   4,  16,  15,  -1,  0};

        rst = 1'b1;
        start = 1'b0;
        num_rows = '0;
        num_cols = '0;
        base_addr = '0;
        bus.gon_enable = 1'b0;
        bus.gon_value = '0;
        bus.glb_ready = 1'b0;
        @(negedge clk);
        chk("reset_outputs", longint'({busy, done, err, bus.gon_ready, bus.gon_row_tag, bus.gon_col_tag,
                                       bus.glb_valid, bus.glb_addr, bus.glb_data}), 0);
        step(1'b0);
        rst = 1'b0;
        step(1'b0);
        @(negedge clk);
        chk("idle_after_reset", longint'({busy, done, err, bus.gon_ready, bus.glb_valid}), 0);

        for (int i = 0; i < 5; i++) run_vec(vt[i], i);

        // Reset in the middle of WAIT with two words held in the FIFO.
        @(posedge clk);
        #1;
        job++;
        allowed = 99;
        c = 0;
        in_job = 1'b1;
        num_rows = 4'd2; num_cols = 5'd3; base_addr = 16'h0500;
        bus.glb_ready = 1'b0;
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        while (c < 8) step(1'b0);
        @(negedge clk);
        chk("pre_rst_fifo_valid", bus.glb_valid, 1);
        chk("pre_rst_busy", busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_job = 1'b0;
        #1;
        chk("mid_job_rst_outputs", longint'({busy, done, err, bus.gon_ready, bus.gon_row_tag, bus.gon_col_tag,
                                             bus.glb_valid, bus.glb_addr, bus.glb_data}), 0);
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        bus.glb_ready = 1'b1;
        step(1'b0);
        @(negedge clk);
        chk("post_rst_fifo_empty", bus.glb_valid, 0);

        // Stray GON response while idle.
        step(1'b1);
        step(1'b0);
        chk("stray_enable_err", err, 1);
        chk("stray_enable_no_push", bus.glb_valid, 0);

        run_vec(clean, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
